// File: rtl/tx_anc.sv
// tx_anc: transmit-side ANC upconverter.
// Rotates baseband IQ by an NCO phase with a pipelined, stallable CORDIC and
// emits saturated IQ over a valid/ready handshake.
// Optional build macro TX_ANC_GAIN_COMP_EN: compensates the CORDIC gain with a
// Q16 multiply (one extra stage); without it the output is halved instead.
module tx_anc #(
  parameter int PHASE_WIDTH   = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int CORDIC_STAGES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         srst,
  input  logic signed [DATA_WIDTH-1:0] ibb_in,
  input  logic signed [DATA_WIDTH-1:0] qbb_in,
  input  logic                         in_tvalid,
  input  logic                         in_tlast,
  output logic                         in_tready,
  input  logic [PHASE_WIDTH-1:0]       phase_inc,
  input  logic                         phase_inc_load,
  output logic signed [DATA_WIDTH-1:0] itx,
  output logic signed [DATA_WIDTH-1:0] qtx,
  output logic                         out_tvalid,
  output logic                         out_tlast,
  input  logic                         out_tready,
  output logic [PHASE_WIDTH-1:0]       ph
);

  // x/y carry 3 guard bits: quadrant negation of the most negative input plus CORDIC growth.
  localparam int XW = DATA_WIDTH + 3;
  localparam int ZW = PHASE_WIDTH;
  localparam int SW = XW + 18;
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  // atan(2^-k) in phase units (2^PHASE_WIDTH per turn), rounded to nearest.
  function automatic int atan_const(input int k);
    real x, x2, term, acc, scale;
    x = 1.0;
    for (int i = 0; i < k; i++) x = x / 2.0;
    acc = 0.0;
    if (k == 0) begin
      acc = 0.78539816339744830962;
    end else begin
      term = x;
      x2   = x * x;
      for (int n = 0; n < 20; n++) begin
        if (n % 2 == 0) acc = acc + term / real'(2*n + 1);
        else            acc = acc - term / real'(2*n + 1);
        term = term * x2;
      end
    end
    scale = 1.0;
    for (int i = 0; i < PHASE_WIDTH; i++) scale = scale * 2.0;
    scale = scale / 6.28318530717958647692;
    return $rtoi(acc * scale + 0.5);
  endfunction

  function automatic logic [CORDIC_STAGES*ZW-1:0] atan_table();
    logic [CORDIC_STAGES*ZW-1:0] t;
    t = '0;
    for (int k = 0; k < CORDIC_STAGES; k++) t[k*ZW +: ZW] = ZW'(atan_const(k));
    return t;
  endfunction

  localparam logic [CORDIC_STAGES*ZW-1:0] ATAN_TAB = atan_table();

  function automatic logic signed [SW-1:0] rnd_shift(input logic signed [SW-1:0] v, input int sh);
    return (v + (SW'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[DATA_WIDTH-1:0];
    else if (v < SAT_LO) r = SAT_LO[DATA_WIDTH-1:0];
    else                 r = v[DATA_WIDTH-1:0];
    return r;
  endfunction

  logic                   ce, accept;
  logic [PHASE_WIDTH-1:0] inc_r, ph_r;
  logic signed [XW-1:0]   i_ext, q_ext, pre_x, pre_y;
  logic signed [ZW-1:0]   pre_z;
  logic signed [XW-1:0]   x_p [0:CORDIC_STAGES];
  logic signed [XW-1:0]   y_p [0:CORDIC_STAGES];
  logic signed [ZW-1:0]   z_p [0:CORDIC_STAGES];
  logic [CORDIC_STAGES:0] vld_p, last_p;
  logic signed [SW-1:0]   x_fin, y_fin;
  logic                   vld_fin, last_fin;

  assign ce        = !out_tvalid || out_tready;
  assign in_tready = ce;
  assign accept    = in_tvalid && ce;
  assign ph        = ph_r;
  assign i_ext     = XW'(ibb_in);
  assign q_ext     = XW'(qbb_in);
  assign pre_z     = signed'({2'b00, ph_r[PHASE_WIDTH-3:0]});

  // Phase accumulator advances once per accepted sample; a same-cycle load applies to the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_r <= '0;
      ph_r  <= '0;
    end else begin
      if (phase_inc_load) inc_r <= phase_inc;
      if (srst)           ph_r  <= '0;
      else if (accept)    ph_r  <= ph_r + inc_r;
    end
  end

  // Quadrant pre-rotation leaves a residual angle in [0, pi/2) for the CORDIC.
  always_comb begin
    pre_x = i_ext;
    pre_y = q_ext;
    case (ph_r[PHASE_WIDTH-1 -: 2])
      2'b01:   begin pre_x = -q_ext; pre_y =  i_ext; end
      2'b10:   begin pre_x = -i_ext; pre_y = -q_ext; end
      2'b11:   begin pre_x =  q_ext; pre_y = -i_ext; end
      default: begin pre_x =  i_ext; pre_y =  q_ext; end
    endcase
  end

  // Stage 0 register followed by CORDIC_STAGES rotation-mode micro-rotations.
  always_ff @(posedge clk) begin
    if (ce) begin
      x_p[0] <= pre_x;
      y_p[0] <= pre_y;
      z_p[0] <= pre_z;
      last_p <= {last_p[CORDIC_STAGES-1:0], in_tlast};
      for (int s = 1; s <= CORDIC_STAGES; s++) begin
        if (!z_p[s-1][ZW-1]) begin
          x_p[s] <= x_p[s-1] - (y_p[s-1] >>> (s-1));
          y_p[s] <= y_p[s-1] + (x_p[s-1] >>> (s-1));
          z_p[s] <= z_p[s-1] - signed'(ATAN_TAB[(s-1)*ZW +: ZW]);
        end else begin
          x_p[s] <= x_p[s-1] + (y_p[s-1] >>> (s-1));
          y_p[s] <= y_p[s-1] - (x_p[s-1] >>> (s-1));
          z_p[s] <= z_p[s-1] + signed'(ATAN_TAB[(s-1)*ZW +: ZW]);
        end
      end
    end
  end

  // Stage valids: cleared by either reset, otherwise shifted on ce.
  always_ff @(posedge clk) begin
    if (reset || srst) vld_p <= '0;
    else if (ce)       vld_p <= {vld_p[CORDIC_STAGES-1:0], accept};
  end

`ifdef TX_ANC_GAIN_COMP_EN
  localparam logic signed [SW-1:0] GAIN_Q16 = SW'(39797);
  logic signed [SW-1:0] xm_p, ym_p;
  logic                 vld_m, last_m;

  // Gain-compensation multiply stage.
  always_ff @(posedge clk) begin
    if (ce) begin
      xm_p   <= SW'(x_p[CORDIC_STAGES]) * GAIN_Q16;
      ym_p   <= SW'(y_p[CORDIC_STAGES]) * GAIN_Q16;
      last_m <= last_p[CORDIC_STAGES];
    end
  end

  // Valid for the multiply stage.
  always_ff @(posedge clk) begin
    if (reset || srst) vld_m <= 1'b0;
    else if (ce)       vld_m <= vld_p[CORDIC_STAGES];
  end

  assign x_fin    = rnd_shift(xm_p, 16);
  assign y_fin    = rnd_shift(ym_p, 16);
  assign vld_fin  = vld_m;
  assign last_fin = last_m;
`else
  assign x_fin    = rnd_shift(SW'(x_p[CORDIC_STAGES]), 1);
  assign y_fin    = rnd_shift(SW'(y_p[CORDIC_STAGES]), 1);
  assign vld_fin  = vld_p[CORDIC_STAGES];
  assign last_fin = last_p[CORDIC_STAGES];
`endif

  // Output register: saturated IQ, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      itx        <= '0;
      qtx        <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (srst) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (ce) begin
      itx        <= sat(x_fin);
      qtx        <= sat(y_fin);
      out_tvalid <= vld_fin;
      out_tlast  <= last_fin && vld_fin;
    end
  end

endmodule

// File: tb/tb_tx_anc.sv
// tb_tx_anc: directed and randomized checks of tx_anc against an ideal
// trigonometric rotation model with a transaction scoreboard.
module tb_tx_anc;
  localparam int PW = 24;
  localparam int DW = 16;
  localparam int NS = 16;
`ifdef TX_ANC_GAIN_COMP_EN
  localparam int  LAT   = NS + 3;
  localparam real GC    = 39797.0 / 65536.0;
  localparam int  FULL1 = 32767;
`else
  localparam int  LAT   = NS + 2;
  localparam real GC    = 0.5;
  localparam int  FULL1 = 26980;
`endif

  logic clk = 1'b0;
  logic reset, srst, in_tvalid, in_tlast, in_tready, phase_inc_load;
  logic out_tvalid, out_tlast, out_tready;
  logic signed [DW-1:0] ibb_in, qbb_in, itx, qtx;
  logic [PW-1:0] phase_inc, ph;

  tx_anc #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW), .CORDIC_STAGES(NS)) dut (
    .clk(clk), .reset(reset), .srst(srst),
    .ibb_in(ibb_in), .qbb_in(qbb_in),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .phase_inc(phase_inc), .phase_inc_load(phase_inc_load),
    .itx(itx), .qtx(qtx),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .ph(ph)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  real kg;
  logic [PW-1:0] ph_m, inc_m;
  int exp_i[$];
  int exp_q[$];
  bit exp_l[$];
  bit hold_prev;
  int prev_i, prev_q;
  bit prev_l;
  bit acc_flag;
  logic rdy_seen;
  int last_pop_i, last_pop_q, tlast_cnt;

  task automatic chk(input bit ok, input string tag, input int got, input int want);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic bit near(input int a, input int b);
    return (a - b <= 4) && (b - a <= 4);
  endfunction

  // Ideal rotation by 2*pi*phase/2^PW, scaled by the CORDIC gain and output scaling.
  function automatic int ref_out(input int a, input int b, input logic [PW-1:0] phv, input bit want_q);
    real th, v;
    th = 6.283185307179586 * real'(phv) / real'(64'd1 << PW);
    if (want_q) v = real'(a) * $sin(th) + real'(b) * $cos(th);
    else        v = real'(a) * $cos(th) - real'(b) * $sin(th);
    v = $floor(v * kg * GC + 0.5);
    if (v > 32767.0)  v = 32767.0;
    if (v < -32768.0) v = -32768.0;
    return $rtoi(v);
  endfunction

  task automatic step(input bit tv, input int i, input int q, input bit last, input bit rdy,
                      input bit ld, input logic [PW-1:0] incv, input bit sr);
    int gi, gq;
    bit gl;
    in_tvalid = tv; ibb_in = i[DW-1:0]; qbb_in = q[DW-1:0]; in_tlast = last;
    out_tready = rdy; phase_inc_load = ld; phase_inc = incv; srst = sr;
    #1;
    rdy_seen = in_tready;
    chk(ph === ph_m, "ph", int'(ph), int'(ph_m));
    chk(in_tready === (!out_tvalid || out_tready), "in_tready", int'(in_tready), int'(!out_tvalid || out_tready));
    if (hold_prev)
      chk(out_tvalid === 1'b1 && int'(itx) == prev_i && int'(qtx) == prev_q && out_tlast === prev_l,
          "hold", int'(itx), prev_i);
    if (out_tvalid === 1'b1 && rdy) begin
      chk(exp_i.size() > 0, "extra_output", int'(itx), 0);
      if (exp_i.size() > 0) begin
        gi = exp_i.pop_front(); gq = exp_q.pop_front(); gl = exp_l.pop_front();
        chk(near(int'(itx), gi), "itx", int'(itx), gi);
        chk(near(int'(qtx), gq), "qtx", int'(qtx), gq);
        chk(out_tlast === gl, "tlast", int'(out_tlast), int'(gl));
        last_pop_i = int'(itx); last_pop_q = int'(qtx);
        if (out_tlast === 1'b1) tlast_cnt++;
      end
    end
    hold_prev = (out_tvalid === 1'b1) && !rdy && !sr;
    prev_i = int'(itx); prev_q = int'(qtx); prev_l = out_tlast;
    acc_flag = tv && (in_tready === 1'b1) && !sr;
    if (acc_flag) begin
      exp_i.push_back(ref_out(i, q, ph_m, 1'b0));
      exp_q.push_back(ref_out(i, q, ph_m, 1'b1));
      exp_l.push_back(last);
      ph_m = ph_m + inc_m;
    end
    if (sr) begin
      ph_m = '0;
      exp_i.delete(); exp_q.delete(); exp_l.delete();
    end
    if (ld) inc_m = incv;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_i.size() > 0 || out_tvalid === 1'b1) && k < 200) begin
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      k++;
    end
    chk(exp_i.size() == 0 && out_tvalid !== 1'b1, "drain", exp_i.size(), 0);
  endtask

  initial begin
    int first, sent;
    real p;
    kg = 1.0; p = 1.0;
    for (int k = 0; k < NS; k++) begin kg = kg * $sqrt(1.0 + p); p = p / 4.0; end
    hold_prev = 0; tlast_cnt = 0; last_pop_i = 0; last_pop_q = 0;

    // Reset with busy inputs, including an increment load that must be ignored.
    reset = 1'b1; srst = 1'b0; in_tvalid = 1'b1; in_tlast = 1'b1; ibb_in = 16'sd1234; qbb_in = -16'sd77;
    out_tready = 1'b0; phase_inc_load = 1'b1; phase_inc = 24'h5A5A5A;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; phase_inc_load = 1'b0; out_tready = 1'b1;
    ph_m = '0; inc_m = '0;
    #1;
    chk(itx === 16'sd0, "rst_itx", int'(itx), 0);
    chk(qtx === 16'sd0, "rst_qtx", int'(qtx), 0);
    chk(ph === '0, "rst_ph", int'(ph), 0);
    chk(out_tvalid === 1'b0, "rst_vld", int'(out_tvalid), 0);
    chk(out_tlast === 1'b0, "rst_last", int'(out_tlast), 0);
    chk(in_tready === 1'b1, "rst_rdy", int'(in_tready), 1);

    // DC tone: inc=0, full-scale I; latency and steady output.
    first = -1;
    for (int n = 0; n < LAT + 12; n++) begin
      if (out_tvalid === 1'b1 && first < 0) first = n;
      if (n > LAT) chk(out_tvalid === 1'b1, "continuous", int'(out_tvalid), 1);
      step(1'b1, 32767, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    end
    chk(first == LAT, "latency", first, LAT);
    chk(near(int'(itx), FULL1) && near(int'(qtx), 0), "dc_tone", int'(itx), FULL1);

    // 90 degrees per sample.
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 24'h400000, 1'b0);
    for (int n = 0; n < 8; n++) begin
      chk(ph === PW'((n % 4) * 24'h400000), "ph_quad", int'(ph), (n % 4) * 4194304);
      step(1'b1, 16384, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    end
    drain();

    // Saturation at 45 degrees.
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 24'h200000, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 32767, 32767, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    drain();
    chk(last_pop_q == 32767, "sat_q", last_pop_q, 32767);
    chk(near(last_pop_i, 0), "sat_i", last_pop_i, 0);

    // Ramp with a 5-cycle downstream stall and tlast on sample 10.
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 24'd12345, 1'b0);
    sent = 0; tlast_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      step(sent < 30, 1000 * sent - 15000, 14000 - 900 * sent, sent == 10,
           !(n >= 22 && n < 27), 1'b0, '0, 1'b0);
      if (n >= 22 && n < 27) chk(rdy_seen === 1'b0, "stall_rdy", int'(rdy_seen), 0);
      if (acc_flag) sent++;
    end
    drain();
    chk(sent == 30, "ramp_sent", sent, 30);
    chk(tlast_cnt == 1, "tlast_cnt", tlast_cnt, 1);

    // Soft reset with 7 samples in flight; srst also coincides with a valid input.
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 24'h100000, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b1, 2000 * n + 100, -3000 * n, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 5000, 5000, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk(out_tvalid === 1'b0, "srst_vld", int'(out_tvalid), 0);
    chk(ph === '0, "srst_ph", int'(ph), 0);
    step(1'b1, 30000, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk(ph === 24'h100000, "inc_kept", int'(ph), 1048576);
    drain();
    chk(near(last_pop_q, 0), "srst_phase0_q", last_pop_q, 0);

    // Randomized traffic, backpressure, loads and occasional soft resets.
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 4) != 0,
           int'($urandom_range(65535, 0)) - 32768,
           int'($urandom_range(65535, 0)) - 32768,
           ($urandom % 8) == 0,
           ($urandom % 4) != 0,
           ($urandom % 32) == 0,
           PW'($urandom),
           ($urandom % 97) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_anc.md
Name: tx_anc

Overview:
- Transmit-side counterpart of the RX ANC downconverter.
- Accepts baseband IQ samples from the TX datapath and upconverts them to the ANC tone frequency.
- Rotates each sample by a programmable NCO phase using a pipelined, stallable CORDIC, so no multipliers are needed.
- Output is saturated IQ with an AXI-stream-style handshake, placed ahead of the DAC/radio TX interface.

Parameters:
- PHASE_WIDTH, 24, width of the phase accumulator and phase increment; full scale is 2π.
- DATA_WIDTH, 16, width of the signed two's-complement IQ input and output.
- CORDIC_STAGES, 16, number of CORDIC iterations; legal range 8..PHASE_WIDTH-2.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high; clears all state
- srst  in  1  synchronous soft reset; clears pipeline valids and phase accumulator, keeps phase_inc
- ibb_in  in  DATA_WIDTH  baseband I, signed
- qbb_in  in  DATA_WIDTH  baseband Q, signed
- in_tvalid  in  1  input sample valid
- in_tlast  in  1  end of packet, travels with the sample
- in_tready  out  1  block can accept a sample this cycle
- phase_inc  in  PHASE_WIDTH  per-sample phase step, unsigned
- phase_inc_load  in  1  latch phase_inc into the internal increment register
- itx  out  DATA_WIDTH  upconverted I, signed
- qtx  out  DATA_WIDTH  upconverted Q, signed
- out_tvalid  out  1  output valid
- out_tlast  out  1  end of packet
- out_tready  in  1  downstream ready
- ph  out  PHASE_WIDTH  debug: current phase accumulator value

Behaviour:
- Reset (reset=1 at a clk edge):
  - itx, qtx, ph, out_tvalid, out_tlast and the increment register all go to 0.
  - All stage valids go to 0.
  - in_tready is 1 in the first cycle after reset.
- Pipeline enable: ce = !out_tvalid || out_tready.
  - in_tready = ce, combinational.
  - When ce=0 every stage holds, including outputs.
- Accept: a sample is accepted when in_tvalid && in_tready.
  - The accepted sample is paired with the current ph.
  - ph <= ph + inc, modulo 2^PHASE_WIDTH.
  - ph advances only on accept; idle cycles do not move the phase.
- Increment load: on phase_inc_load, inc <= phase_inc, taking effect for the next accepted sample.
  - If load and accept coincide, the accept uses the old inc.
- Stage 0 (quadrant pre-rotation), selected by the top 2 bits of the phase:
  - 00: (i, q)
  - 01: (-q, i)
  - 10: (-i, -q)
  - 11: (q, -i)
  - The residual angle (lower PHASE_WIDTH-2 bits, range [0, π/2)) becomes z.
  - Internal x/y width is DATA_WIDTH+3.
  - Negation of -2^(DATA_WIDTH-1) must not wrap; the widened path guarantees this.
- Stages 1..CORDIC_STAGES (CORDIC rotation mode):
  - d = sign(z)
  - x' = x - d·(y>>>k)
  - y' = y + d·(x>>>k)
  - z' = z - d·atan(2^-k), with k = stage-1.
  - The atan constants are scaled to 2^PHASE_WIDTH/(2π), rounded to nearest, and generated by a constant function.
- Output stage:
  - Gain scaling per Optional Feature, then round-half-up.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency: CORDIC_STAGES+2 enabled cycles from accept to out_tvalid (18 at defaults).
- tlast is delayed alongside its sample.
- Backpressure:
  - No sample is dropped or duplicated.
  - While out_tvalid=1 && out_tready=0, itx/qtx/out_tlast are stable.
- srst:
  - Next cycle: all valids are 0, out_tvalid=0, ph=0.
  - Samples in flight are discarded; inc is retained.
  - srst takes priority over a simultaneous accept.
  - reset takes priority over srst.

Optional Feature:
- TX_ANC_GAIN_COMP_EN
- Defined: the output multiplies by the CORDIC gain inverse 0.607253 (Q16 constant 39797), so unity gain ±4 LSB. This adds one pipeline stage, giving latency CORDIC_STAGES+3.
- Undefined: the output is an arithmetic shift right by 1, giving net gain ≈0.8234 and no multiplier. Latency CORDIC_STAGES+2.

Test Plan:
- inc=0, input (32767,0) continuous, out_tready=1 -> after 18 cycles itx=26980±4, qtx=0±4 (COMP_EN: 32767±4), out_tvalid continuous.
- inc=2^22 (90°/sample), input (16384,0) -> outputs cycle (13490,0),(0,13490),(-13490,0),(0,-13490) ±4; ph reads 0,2^22,2^23,3·2^22.
- Saturation, comp off: inc=2^21 with ph at 2^21 (45°), input (32767,32767) -> qtx=32767 saturated, itx=0±4.
- Backpressure: ramp input, out_tready low 5 cycles mid-stream -> in_tready low those cycles, outputs held, output sequence equals input sequence with no gaps or repeats, ph advances once per accept.
- in_tlast on sample 10 -> out_tlast high only with output sample 10.
- srst asserted with 7 samples in flight -> out_tvalid=0 next cycle, those samples never appear, ph=0, inc unchanged; next accepted sample rotated by phase 0.
